stream_fork2: RTL and testbench

Two-way stream fork: every beat accepted on input stream A is delivered once to output stream B and once to output stream C, in order. Each branch has its own 2-entry buffer, so one slow consumer stalls the other only after its buffer fills. It sits between a single producer and two independent consumers that use valid/ready handshakes, with no combinational path from any ready to `a_ready`.

---
 rtl/stream_fork2.sv | 122 ++++++++++++
 tb/tb_stream_fork2.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/stream_fork2.sv
// Two-way stream fork: each beat accepted on A is delivered once to B and once to C, in order.
// Each branch has its own 2-entry FIFO. Define STREAM_FORK_ASSERT_EN to compile in simulation-only protocol checkers.
module stream_fork2 #(
  parameter int DATA_BW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_BW-1:0] a_data,
  input  logic               a_valid,
  output logic               a_ready,
  output logic [DATA_BW-1:0] b_data,
  output logic               b_valid,
  input  logic               b_ready,
  output logic [DATA_BW-1:0] c_data,
  output logic               c_valid,
  input  logic               c_ready
);

  logic [DATA_BW-1:0] mem_b [2];
  logic [DATA_BW-1:0] mem_c [2];
  logic               rptr_b, wptr_b, rptr_c, wptr_c;
  logic [1:0]         cnt_b, cnt_c;
  logic [1:0]         cnt_b_nxt, cnt_c_nxt;
  logic               a_fire, b_fire, c_fire;
  logic               a_ready_nxt;

  // Occupancy after one edge. A simultaneous push and pop leaves the count unchanged.
  function automatic logic [1:0] next_count(input logic [1:0] cnt, input logic push,
                                            input logic pop);
    logic [1:0] res;
    res = cnt;
    if (push && !pop)
      res = cnt + 2'd1;
    else if (!push && pop)
      res = cnt - 2'd1;
    return res;
  endfunction

  assign a_fire = a_valid && a_ready;
  assign b_fire = b_valid && b_ready;
  assign c_fire = c_valid && c_ready;

  assign b_valid = (cnt_b != 2'd0);
  assign c_valid = (cnt_c != 2'd0);
  assign b_data  = mem_b[rptr_b];
  assign c_data  = mem_c[rptr_c];

  always_comb begin
    cnt_b_nxt   = next_count(cnt_b, a_fire, b_fire);
    cnt_c_nxt   = next_count(cnt_c, a_fire, c_fire);
    // Registered ready: depends only on the next state, never on b_ready/c_ready in the same cycle.
    a_ready_nxt = (cnt_b_nxt < 2'd2) && (cnt_c_nxt < 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_b[0] <= '0;
      mem_b[1] <= '0;
      mem_c[0] <= '0;
      mem_c[1] <= '0;
      rptr_b   <= 1'b0;
      wptr_b   <= 1'b0;
      rptr_c   <= 1'b0;
      wptr_c   <= 1'b0;
      cnt_b    <= 2'd0;
      cnt_c    <= 2'd0;
      a_ready  <= 1'b1;
    end else begin
      if (a_fire) begin
        mem_b[wptr_b] <= a_data;
        mem_c[wptr_c] <= a_data;
        wptr_b        <= ~wptr_b;
        wptr_c        <= ~wptr_c;
      end
      if (b_fire)
        rptr_b <= ~rptr_b;
      if (c_fire)
        rptr_c <= ~rptr_c;
      cnt_b   <= cnt_b_nxt;
      cnt_c   <= cnt_c_nxt;
      a_ready <= a_ready_nxt;
    end
  end

`ifdef STREAM_FORK_ASSERT_EN
  logic               a_hold_q, b_hold_q, c_hold_q;
  logic [DATA_BW-1:0] a_data_q, b_data_q, c_data_q;

  // Remember which ports were stalled at the previous edge so their hold rules can be checked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_hold_q <= 1'b0;
      b_hold_q <= 1'b0;
      c_hold_q <= 1'b0;
      a_data_q <= '0;
      b_data_q <= '0;
      c_data_q <= '0;
    end else begin
      a_hold_q <= a_valid && !a_ready;
      b_hold_q <= b_valid && !b_ready;
      c_hold_q <= c_valid && !c_ready;
      a_data_q <= a_data;
      b_data_q <= b_data;
      c_data_q <= c_data;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (a_hold_q && (!a_valid || a_data != a_data_q))
        $error("stream_fork2: a_valid/a_data changed while stalled");
      if (cnt_b == 2'd3 || cnt_c == 2'd3)
        $error("stream_fork2: branch count exceeds 2");
      if (b_hold_q && (!b_valid || b_data != b_data_q))
        $error("stream_fork2: b_valid/b_data changed while stalled");
      if (c_hold_q && (!c_valid || c_data != c_data_q))
        $error("stream_fork2: c_valid/c_data changed while stalled");
    end
  end
`endif

endmodule

// File: tb/tb_stream_fork2.sv
// Randomized and directed bench for stream_fork2, checked against a queue-based model of both branches.
module tb_stream_fork2;
  localparam int DW = 4;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] a_data;
  logic          a_valid;
  logic          a_ready;
  logic [DW-1:0] b_data;
  logic          b_valid;
  logic          b_ready;
  logic [DW-1:0] c_data;
  logic          c_valid;
  logic          c_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] qb[$];
  logic [DW-1:0] qc[$];
  logic          exp_ar = 1'b1;
  logic          last_afire = 1'b0;

  stream_fork2 #(.DATA_BW(DW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a_data (a_data),
    .a_valid(a_valid),
    .a_ready(a_ready),
    .b_data (b_data),
    .b_valid(b_valid),
    .b_ready(b_ready),
    .c_data (c_data),
    .c_valid(c_valid),
    .c_ready(c_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    check_eq("a_ready", a_ready, exp_ar);
    check_eq("b_valid", b_valid, qb.size() != 0);
    check_eq("c_valid", c_valid, qc.size() != 0);
    if (qb.size() != 0) check_eq("b_data", b_data, qb[0]);
    if (qc.size() != 0) check_eq("c_data", c_data, qc[0]);
  endtask

  // Drive one cycle's inputs, advance the model at the edge, compare at the following negedge.
  task automatic step(input logic av, input logic [DW-1:0] ad, input logic br, input logic cr);
    logic bf, cf;
    a_valid = av;
    a_data  = ad;
    b_ready = br;
    c_ready = cr;
    @(posedge clk);
    last_afire = a_valid && exp_ar;
    bf = b_ready && (qb.size() != 0);
    cf = c_ready && (qc.size() != 0);
    if (bf) void'(qb.pop_front());
    if (cf) void'(qc.pop_front());
    if (last_afire) begin
      qb.push_back(a_data);
      qc.push_back(a_data);
    end
    exp_ar = (qb.size() < 2) && (qc.size() < 2);
    @(negedge clk);
    compare_outputs();
  endtask

  initial begin
    logic [DW-1:0] dcount;
    logic          hold;
    logic          av;
    rst_n   = 1'b0;
    a_valid = 1'b0;
    a_data  = '0;
    b_ready = 1'b0;
    c_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_a_ready", a_ready, 1'b1);
    check_eq("rst_b_valid", b_valid, 1'b0);
    check_eq("rst_c_valid", c_valid, 1'b0);
    check_eq("rst_b_data", b_data, 0);
    check_eq("rst_c_data", c_data, 0);
    rst_n = 1'b1;

    // Full-rate streaming with both consumers ready.
    for (int i = 0; i < 20; i++) step(1'b1, DW'(i), 1'b1, 1'b1);
    check_eq("stream_ar", a_ready, 1'b1);
    repeat (3) step(1'b0, '0, 1'b1, 1'b1);

    // B stalled, C ready: third beat is held off until B drains.
    step(1'b1, 4'd0, 1'b0, 1'b1);
    step(1'b1, 4'd1, 1'b0, 1'b1);
    check_eq("bstall_ar", a_ready, 1'b0);
    step(1'b1, 4'd2, 1'b0, 1'b1);
    check_eq("bstall_b_data", b_data, 4'd0);
    step(1'b1, 4'd2, 1'b1, 1'b1);
    step(1'b1, 4'd2, 1'b1, 1'b1);
    if (!last_afire) step(1'b1, 4'd2, 1'b1, 1'b1);
    repeat (4) step(1'b0, '0, 1'b1, 1'b1);

    // Both stalled with two beats buffered, then only C drains.
    step(1'b1, 4'd5, 1'b0, 1'b0);
    step(1'b1, 4'd6, 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0, 1'b1);
    check_eq("cdrain_c_valid", c_valid, 1'b0);
    check_eq("cdrain_b_valid", b_valid, 1'b1);
    check_eq("cdrain_b_data", b_data, 4'd5);
    check_eq("cdrain_ar", a_ready, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b1);

    // Simultaneous push and pop on B while C lags.
    step(1'b1, 4'd3, 1'b0, 1'b0);
    step(1'b1, 4'd4, 1'b1, 1'b0);
    check_eq("pushpop_b_data", b_data, 4'd4);
    repeat (4) step(1'b0, '0, 1'b1, 1'b1);

    // Random traffic with a counting producer that holds stalled beats.
    dcount = '0;
    hold   = 1'b0;
    for (int i = 0; i < 500; i++) begin
      av = hold ? 1'b1 : 1'($urandom_range(0, 1));
      step(av, dcount, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (last_afire) dcount = dcount + 1'b1;
      hold = av && !last_afire;
    end
    repeat (4) step(1'b0, '0, 1'b1, 1'b1);

    // Asynchronous reset with both buffers full.
    step(1'b1, 4'd7, 1'b0, 1'b0);
    step(1'b1, 4'd8, 1'b0, 1'b0);
    a_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    check_eq("arst_b_valid", b_valid, 1'b0);
    check_eq("arst_c_valid", c_valid, 1'b0);
    check_eq("arst_b_data", b_data, 0);
    check_eq("arst_c_data", c_data, 0);
    check_eq("arst_a_ready", a_ready, 1'b1);
    qb.delete();
    qc.delete();
    exp_ar = 1'b1;
    #2;
    rst_n = 1'b1;
    step(1'b1, 4'd9, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    check_eq("post_rst_b_valid", b_valid, 1'b0);
    check_eq("post_rst_c_valid", c_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
